// File: rtl/text_pixel_pipeline.sv
// Text-mode pixel generator: VRAM character fetch, font lookup, palette colour, blinking cursor.
// Latency VRAM_LAT+2 cycles, syncs delay-matched; one pixel per cycle, no stalls or backpressure.
module text_pixel_pipeline #(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int GLYPH_H      = 16,
  parameter int VRAM_LAT     = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                               pixel_clk,
  input  logic                               reset,
  input  logic [9:0]                         draw_x,
  input  logic [9:0]                         draw_y,
  input  logic                               hsync_i,
  input  logic                               vsync_i,
  input  logic                               vde_i,
  output logic [$clog2(COLS*ROWS/2)-1:0]     vram_addr,
  input  logic [31:0]                        vram_rdata,
  input  logic [16*12-1:0]                   palette,
  input  logic                               cursor_en,
  input  logic [6:0]                         cursor_col,
  input  logic [4:0]                         cursor_row,
  output logic [3:0]                         red,
  output logic [3:0]                         green,
  output logic [3:0]                         blue,
  output logic                               hsync_o,
  output logic                               vsync_o,
  output logic                               vde_o
);
  localparam int AW    = $clog2(COLS * ROWS / 2);
  localparam int CELLW = AW + 1;
  localparam int LW    = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam int L     = VRAM_LAT + 2;
  localparam int SW    = LW + 6;
  localparam int CW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic {PHASE_OFF, PHASE_ON} phase_t;

  logic [6:0]       col_s0;
  logic [9:0]       row_s0;
  logic [LW-1:0]    line_s0;
  logic [CELLW-1:0] cell_s0;
  logic             in_region_s0;
  logic             hit_s0;
  logic [SW-1:0]    side_s0;

  always_comb begin
    col_s0       = draw_x[9:3];
    row_s0       = draw_y / 10'(GLYPH_H);
    line_s0      = LW'(draw_y % 10'(GLYPH_H));
    cell_s0      = CELLW'(int'(row_s0) * COLS + int'(col_s0));
    in_region_s0 = (int'(draw_x) < COLS * 8) && (int'(draw_y) < ROWS * GLYPH_H);
    hit_s0       = cursor_en && (col_s0 == cursor_col) && (row_s0 == 10'(cursor_row));
    vram_addr    = in_region_s0 ? cell_s0[CELLW-1:1] : '0;
    // The visible flag folds vde and region so stage B needs a single gate.
    side_s0      = {vde_i & in_region_s0, hit_s0, cell_s0[0], draw_x[2:0], line_s0};
  end

  logic [SW-1:0] side_q [VRAM_LAT];
  logic [L-1:0]  hs_q, vs_q, de_q;

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      for (int i = 0; i < VRAM_LAT; i++) side_q[i] <= '0;
      hs_q <= '1;
      vs_q <= '1;
      de_q <= '0;
    end else begin
      side_q[0] <= side_s0;
      for (int i = 1; i < VRAM_LAT; i++) side_q[i] <= side_q[i-1];
      hs_q <= {hs_q[L-2:0], hsync_i};
      vs_q <= {vs_q[L-2:0], vsync_i};
      de_q <= {de_q[L-2:0], vde_i};
    end
  end

  assign hsync_o = hs_q[L-1];
  assign vsync_o = vs_q[L-1];
  assign vde_o   = de_q[L-1];

  logic          ok_a, hit_a, half_a;
  logic [2:0]    xo_a;
  logic [LW-1:0] line_a;
  logic [15:0]   chr_d;
  logic [7:0]    font_d;

  assign {ok_a, hit_a, half_a, xo_a, line_a} = side_q[VRAM_LAT-1];
  assign chr_d = half_a ? vram_rdata[31:16] : vram_rdata[15:0];

  font_rom #(.GLYPH_H(GLYPH_H), .LW(LW)) u_font_rom (
    .addr_i ({chr_d[14:8], line_a}),
    .data_o (font_d)
  );

  logic [7:0] font_q;
  logic [3:0] fg_q, bg_q;
  logic [2:0] xo_q;
  logic       inv_q, hit_q, ok_q;

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      font_q <= '0;
      inv_q  <= 1'b0;
      fg_q   <= '0;
      bg_q   <= '0;
      xo_q   <= '0;
      hit_q  <= 1'b0;
      ok_q   <= 1'b0;
    end else begin
      font_q <= font_d;
      inv_q  <= chr_d[15];
      fg_q   <= chr_d[7:4];
      bg_q   <= chr_d[3:0];
      xo_q   <= xo_a;
      hit_q  <= hit_a;
      ok_q   <= ok_a;
    end
  end

  phase_t         phase_q, phase_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           vs_prev_q, vs_fall;
  logic           pix_d;
  logic [11:0]    rgb_d, rgb_q;

  always_comb begin
    pix_d = font_q[3'd7 - xo_q] ^ inv_q ^ (hit_q & (phase_q == PHASE_ON));
    rgb_d = 12'h000;
    if (ok_q) rgb_d = pix_d ? palette[12*fg_q +: 12] : palette[12*bg_q +: 12];
  end

  always_comb begin
    vs_fall = vs_prev_q & ~vsync_i;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (vs_fall) begin
      if (cnt_q == CW'(BLINK_FRAMES - 1)) begin
        cnt_d   = '0;
        phase_d = (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      phase_q   <= PHASE_OFF;
      cnt_q     <= '0;
      vs_prev_q <= 1'b1;
      rgb_q     <= '0;
    end else begin
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      vs_prev_q <= vsync_i;
      rgb_q     <= rgb_d;
    end
  end

  assign red   = rgb_q[11:8];
  assign green = rgb_q[7:4];
  assign blue  = rgb_q[3:0];
endmodule

// Combinational glyph ROM, addr = {code, line}: blanks at 0x00/0x20, full block at 0x7F,
// and elsewhere a code-derived bar on every line except the first and last.
module font_rom #(
  parameter int GLYPH_H = 16,
  parameter int LW      = 4
) (
  input  logic [LW+6:0] addr_i,
  output logic [7:0]    data_o
);
  logic [6:0]    code;
  logic [LW-1:0] line;

  always_comb begin
    code   = addr_i[LW+6:LW];
    line   = addr_i[LW-1:0];
    data_o = 8'h00;
    if (code == 7'h7F) begin
      data_o = 8'hFF;
    end else if (code != 7'h00 && code != 7'h20 && line != '0 && line != LW'(GLYPH_H - 1)) begin
      data_o = {code, 1'b0};
    end
  end
endmodule

// File: tb/tb_text_pixel_pipeline.sv
// Drives three builds (VRAM_LAT 2/1/3) with one directed pixel stream and scoreboards every output cycle.
module tb_text_pixel_pipeline;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic [9:0]   draw_x, draw_y;
  logic         hs, vs, de;
  logic [191:0] pal;
  logic         cen;
  logic [6:0]   ccol;
  logic [4:0]   crow;

  logic [10:0] va0, va1, va2;
  logic [31:0] rd0, rd1, rd2;
  logic [3:0]  r0, g0, b0, r1, g1, b1, r2, g2, b2;
  logic        ho0, vo0, deo0, ho1, vo1, deo1, ho2, vo2, deo2;

  text_pixel_pipeline #(.VRAM_LAT(2), .BLINK_FRAMES(2)) u_l2 (
    .pixel_clk(clk), .reset(reset), .draw_x(draw_x), .draw_y(draw_y),
    .hsync_i(hs), .vsync_i(vs), .vde_i(de), .vram_addr(va0), .vram_rdata(rd0),
    .palette(pal), .cursor_en(cen), .cursor_col(ccol), .cursor_row(crow),
    .red(r0), .green(g0), .blue(b0), .hsync_o(ho0), .vsync_o(vo0), .vde_o(deo0));

  text_pixel_pipeline #(.VRAM_LAT(1), .BLINK_FRAMES(2)) u_l1 (
    .pixel_clk(clk), .reset(reset), .draw_x(draw_x), .draw_y(draw_y),
    .hsync_i(hs), .vsync_i(vs), .vde_i(de), .vram_addr(va1), .vram_rdata(rd1),
    .palette(pal), .cursor_en(cen), .cursor_col(ccol), .cursor_row(crow),
    .red(r1), .green(g1), .blue(b1), .hsync_o(ho1), .vsync_o(vo1), .vde_o(deo1));

  text_pixel_pipeline #(.VRAM_LAT(3), .BLINK_FRAMES(2)) u_l3 (
    .pixel_clk(clk), .reset(reset), .draw_x(draw_x), .draw_y(draw_y),
    .hsync_i(hs), .vsync_i(vs), .vde_i(de), .vram_addr(va2), .vram_rdata(rd2),
    .palette(pal), .cursor_en(cen), .cursor_col(ccol), .cursor_row(crow),
    .red(r2), .green(g2), .blue(b2), .hsync_o(ho2), .vsync_o(vo2), .vde_o(deo2));

  // VRAM with 2, 1 and 3 cycles of read latency, one port per build.
  logic [31:0] vram [0:1199];
  logic [31:0] p0 [2];
  logic [31:0] p1 [1];
  logic [31:0] p2 [3];
  always @(posedge clk) begin
    p0[0] <= vram[va0]; p0[1] <= p0[0];
    p1[0] <= vram[va1];
    p2[0] <= vram[va2]; p2[1] <= p2[0]; p2[2] <= p2[1];
  end
  assign rd0 = p0[1];
  assign rd1 = p1[0];
  assign rd2 = p2[2];

  logic [14:0] o0, o1, o2;
  assign o0 = {r0, g0, b0, ho0, vo0, deo0};
  assign o1 = {r1, g1, b1, ho1, vo1, deo1};
  assign o2 = {r2, g2, b2, ho2, vo2, deo2};

  localparam logic [14:0] IDLE = 15'h0006;
  int lat_k [3] = '{4, 3, 5};

  typedef struct {
    int          iss;
    logic [2:0]  live;
    logic [14:0] v;
  } ent_t;

  ent_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic chk_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: each build must show the entry issued L cycles ago, else reset/idle values.
  always @(negedge clk) begin
    logic [14:0] want, act;
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        want = IDLE;
        for (int i = 0; i < sb.size(); i++)
          if (sb[i].iss == cyc - lat_k[k] && sb[i].live[k]) want = sb[i].v;
        act = (k == 0) ? o0 : (k == 1) ? o1 : o2;
        n_chk++;
        if (act !== want) begin
          n_fail++;
          $display("FAIL pixel L=%0d cyc=%0d got rgb/hs/vs/de=%h required=%h", lat_k[k], cyc, act, want);
        end
      end
      while (sb.size() > 0 && sb[0].iss + 5 < cyc) void'(sb.pop_front());
    end
  end

  task automatic chk_addr(input logic [10:0] got, input int want, input int lat);
    n_chk++;
    if (got !== 11'(want)) begin
      n_fail++;
      $display("FAIL vram_addr VRAM_LAT=%0d got=%0d required=%0d", lat, got, want);
    end
  endtask

  task automatic px(input int x, input int y, input logic h, input logic v, input logic d,
                    input logic [11:0] rgb, input int ea);
    ent_t e;
    draw_x = 10'(x);
    draw_y = 10'(y);
    hs = h;
    vs = v;
    de = d;
    if (!reset) begin
      e.iss  = cyc;
      e.live = 3'b111;
      e.v    = {rgb, h, v, d};
      sb.push_back(e);
    end
    if (ea >= 0) begin
      #1;
      chk_addr(va0, ea, 2);
      chk_addr(va1, ea, 1);
      chk_addr(va2, ea, 3);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) px(0, 0, 1'b1, 1'b1, 1'b0, 12'h000, -1);
  endtask

  task automatic vfall();
    px(0, 0, 1'b1, 1'b0, 1'b0, 12'h000, -1);
    idle(6);
  endtask

  task automatic scan3(input int x0, input int y0, input int w, input int h,
                       input int lo, input int hi, input logic [11:0] c_in, input logic [11:0] c_out);
    for (int y = y0; y < y0 + h; y++)
      for (int x = x0; x < x0 + w; x++)
        px(x, y, 1'b1, 1'b1, 1'b1, (x >= lo && x < hi) ? c_in : c_out, -1);
    idle(6);
  endtask

  task automatic do_reset(input int n, input logic vs_low);
    ent_t e;
    reset = 1'b1;
    // Anything not yet out of a pipeline when reset lands is lost.
    for (int i = 0; i < sb.size(); i++) begin
      e = sb[i];
      for (int k = 0; k < 3; k++) if (e.iss + lat_k[k] > cyc) e.live[k] = 1'b0;
      sb[i] = e;
    end
    for (int i = 0; i < n; i++) px(0, 0, 1'b1, (vs_low && i == 1) ? 1'b0 : 1'b1, 1'b1, 12'h000, -1);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1200; i++) vram[i] = 32'h0;
    vram[0] = 32'h0000_0012;
    pal = '0;
    pal[12*1 +: 12] = 12'hFFF;
    pal[12*2 +: 12] = 12'h00F;
    pal[12*3 +: 12] = 12'hF00;
    cen = 1'b1; ccol = 7'd3; crow = 5'd2;
    draw_x = '0; draw_y = '0; hs = 1'b1; vs = 1'b1; de = 1'b1;
    @(posedge clk);
    #1;
    chk_on = 1'b1;
    do_reset(3, 1'b0);

    // first pixel right after release, then a lone vde pulse and a lone hsync pulse
    px(0, 0, 1'b1, 1'b1, 1'b1, 12'h00F, -1);
    idle(6);
    px(0, 0, 1'b1, 1'b1, 1'b1, 12'h00F, -1);
    idle(6);
    px(0, 0, 1'b0, 1'b1, 1'b0, 12'h000, -1);
    idle(6);

    // blank glyph on bg, then the inverted cell on fg
    scan3(0, 0, 8, 16, 0, 8, 12'h00F, 12'h00F);
    vram[0] = 32'h0000_8012;
    scan3(0, 0, 8, 16, 0, 8, 12'hFFF, 12'hFFF);

    // halfword select, address, region edges
    vram[0]    = 32'h0021_0012;
    vram[1199] = 32'h0021_0012;
    px(8,   0,   1'b1, 1'b1, 1'b1, 12'hFFF, 0);
    px(0,   0,   1'b1, 1'b1, 1'b1, 12'h00F, 0);
    px(15,  5,   1'b1, 1'b1, 1'b1, 12'hFFF, 0);
    px(632, 464, 1'b1, 1'b1, 1'b1, 12'hFFF, 1199);
    px(639, 479, 1'b1, 1'b1, 1'b1, 12'hFFF, 1199);
    px(631, 464, 1'b1, 1'b1, 1'b1, 12'h00F, 1199);
    px(640, 0,   1'b1, 1'b1, 1'b1, 12'h000, 0);
    px(0,   480, 1'b1, 1'b1, 1'b1, 12'h000, 0);
    px(1023, 1023, 1'b1, 1'b1, 1'b1, 12'h000, 0);
    idle(6);

    // full-block glyph in cell 10, blank cell 11 beside it
    vram[5] = 32'h0012_7F32;
    scan3(80, 0, 16, 16, 80, 88, 12'hF00, 12'h00F);

    // glyph 0x41: bar 1000_0010 on lines 1..14 -> columns 0 and 6 lit
    vram[6] = 32'h0000_4132;
    for (int y = 0; y < 16; y++)
      for (int o = 0; o < 8; o++)
        px(96 + o, y, 1'b1, 1'b1, 1'b1,
           (y != 0 && y != 15 && (o == 0 || o == 6)) ? 12'hF00 : 12'h00F, -1);
    idle(6);

    // cursor blink at (3,2), two frames per half-period
    vram[80] = 32'h0012_0012;
    vram[81] = 32'h0012_0012;
    vram[82] = 32'h0012_0012;
    scan3(16, 32, 24, 16, 24, 32, 12'h00F, 12'h00F);
    vfall();
    scan3(16, 32, 24, 16, 24, 32, 12'h00F, 12'h00F);
    vfall();
    scan3(16, 32, 24, 16, 24, 32, 12'hFFF, 12'h00F);
    vfall();
    scan3(16, 32, 24, 16, 24, 32, 12'hFFF, 12'h00F);
    vfall();
    scan3(16, 32, 24, 16, 24, 32, 12'h00F, 12'h00F);
    cen = 1'b0;
    vfall();
    vfall();
    scan3(16, 32, 24, 16, 24, 32, 12'h00F, 12'h00F);
    cen = 1'b1;
    idle(2);

    // mid-stream reset with a vsync fall inside it; blink restarts from phase off
    for (int x = 24; x < 30; x++) px(x, 32, 1'b1, 1'b1, 1'b1, 12'hFFF, -1);
    do_reset(3, 1'b1);
    scan3(16, 32, 24, 2, 24, 32, 12'h00F, 12'h00F);
    vfall();
    scan3(16, 32, 24, 2, 24, 32, 12'h00F, 12'h00F);
    vfall();
    scan3(16, 32, 24, 2, 24, 32, 12'hFFF, 12'h00F);

    idle(8);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/text_pixel_pipeline.md
# text_pixel_pipeline

Pipelined text-mode pixel generator: the parametrised successor to the combinational colour mapper in the HDMI text controller. It reads a synchronous VRAM port and an internal font ROM, and resolves per-character foreground/background colours through a 16-entry palette. It adds a blinking hardware cursor. Its video outputs are delay-matched to the sync/enable signals, so it sits between the VGA timing generator and the HDMI encoder.

## Interface
Parameters:
- COLS, 80, character columns (even)
- ROWS, 30, character rows
- GLYPH_H, 16, glyph height in pixel lines (glyph width fixed at 8)
- VRAM_LAT, 2, cycles from vram_addr change to matching vram_rdata (≥1)
- BLINK_FRAMES, 30, frames per cursor blink half-period (≥1)

Ports:
- pixel_clk  in  1  pixel clock; sole clock
- reset  in  1  synchronous, active-high reset
- draw_x  in  10  current pixel column
- draw_y  in  10  current pixel line
- hsync_i  in  1  horizontal sync, active-low
- vsync_i  in  1  vertical sync, active-low
- vde_i  in  1  video data enable
- vram_addr  out  $clog2(COLS*ROWS/2)  VRAM word address
- vram_rdata  in  32  VRAM word, two characters
- palette  in  16*12  flattened palette; entry i = palette[12*i+11 : 12*i], {R[3:0],G[3:0],B[3:0]}
- cursor_en  in  1  cursor enable
- cursor_col  in  7  cursor column
- cursor_row  in  5  cursor row
- red, green, blue  out  4 each  pixel colour
- hsync_o, vsync_o, vde_o  out  1 each  delay-matched syncs and enable

## Operation
- Character cell: col = draw_x>>3, row = draw_y / GLYPH_H, cell = row*COLS + col.
- VRAM address: vram_addr = cell>>1, driven combinationally from draw_x/draw_y at stage 0.
- Half-word select: cell[0]=0 selects vram_rdata[15:0]; cell[0]=1 selects vram_rdata[31:16].
- Character halfword fields: [15] invert, [14:8] glyph code, [7:4] fg index, [3:0] bg index.
- Stage A (after VRAM_LAT): select the halfword, then drive the font_rom instance with addr = {code, line}, where line = draw_y % GLYPH_H (11-bit addr for GLYPH_H=16; font_rom is combinational). Register the font byte, invert, fg/bg indices, pixel offset x[2:0], and the cursor-hit flag.
- Stage B: pix = font[7 − x[2:0]] ^ invert ^ (cursor_hit & blink_phase). pix=1 selects palette[fg], else palette[bg]. Register the result into red/green/blue.
- Blank region: output 0,0,0 when the delayed vde is 0, draw_x ≥ COLS*8, or draw_y ≥ ROWS*GLYPH_H. In the out-of-region case, vram_addr is don't-care but must stay within 0..COLS*ROWS/2−1 (clamp to 0).
- cursor_hit = cursor_en & (col == cursor_col) & (row == cursor_row), computed at stage 0 and delayed.
- Blink FSM (two states, PHASE_OFF and PHASE_ON):
  - A frame counter 0..BLINK_FRAMES−1 increments on each vsync_i falling edge, detected with a registered vsync_i.
  - On a falling edge with counter = BLINK_FRAMES−1, the counter wraps to 0 and blink_phase toggles.
- Palette and cursor inputs are sampled live (no shadowing). A mid-frame change affects pixels from the next stage-A capture onward.

## Timing
- Total latency L = VRAM_LAT + 2 cycles, from draw_x/draw_y/syncs/vde at the input to red/green/blue/hsync_o/vsync_o/vde_o.
- Each sync and vde passes through an L-deep shift register. Pixel offset, cell half-select, line and cursor_hit pass through matching VRAM_LAT-deep delays.
- One pixel per cycle, fully pipelined, no stalls, no backpressure.
- Reset values:
  - red/green/blue: 0
  - hsync_o, vsync_o: 1
  - vde_o: 0
  - all delay-line stages: sync=1, vde=0, data=0
  - blink counter: 0, blink_phase: PHASE_OFF
  - previous-vsync register: 1
- Reset mid-frame: outputs take reset values on the next edge and stay blanked until valid data has propagated L cycles after reset deassertion.
- A vsync falling edge coincident with reset is ignored.

## Test plan
- Reset: hold reset 3 cycles with vde_i=1 → red=green=blue=0, hsync_o=vsync_o=1, vde_o=0 throughout and for L cycles after release.
- Latency: single-cycle vde_i pulse at cycle t (defaults) → vde_o high at exactly t+4 only; hsync_i low pulse delayed identically.
- Blank vs inverted glyph: word 0 = 0x0000_0012, palette[1]=0xFFF, palette[2]=0x00F, scan cell (0,0) → all 128 pixels {0,0,F}. Then word 0 = 0x0000_8012 → all pixels {F,F,F}.
- Half select and address: draw_x=8, draw_y=0 → vram_addr=0, upper halfword used. draw_x=632, draw_y=464 → vram_addr=1199. draw_x=640 with vde_i=1 → output 0,0,0.
- Cursor blink, BLINK_FRAMES=2, cursor_en=1, cursor at (3,2), cell holds 0x0012:
  - after 2 vsync falls → cell (3,2) pixels {F,F,F}, neighbours {0,0,F};
  - after 4 falls → cell (3,2) back to {0,0,F};
  - cursor_en=0 → never inverted.
- VRAM_LAT=1 and VRAM_LAT=3 builds with the same glyph stimulus → identical pixel stream shifted by L = 3 and 5 respectively.
